// File: rtl/moving_average_filter_pkg.sv
// Shared lane constants and types for the 16-bit signed sample path.
package moving_average_filter_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int unsigned sum_width(input int unsigned log2_n);
    return SAMPLE_W + log2_n;
  endfunction

endpackage

// File: rtl/moving_average_filter_sample_ring.sv
// N-entry register ring: exposes the entry about to be overwritten so the
// caller can evict and replace it in the same cycle.
module moving_average_filter_sample_ring
  import moving_average_filter_pkg::*;
#(
  parameter int unsigned LOG2_N = 3
) (
  input  logic    i_clk,
  input  logic    i_reset_n,
  input  logic    i_clear,
  input  logic    i_wr_en,
  input  sample_t i_wr_data,
  output sample_t o_evict
);

  localparam int unsigned N = 1 << LOG2_N;

  sample_t           r_mem [N];
  logic [LOG2_N-1:0] r_wr_ptr;

  assign o_evict = r_mem[r_wr_ptr];

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clear) begin
      for (int unsigned i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
    end else if (i_wr_en) begin
      r_mem[r_wr_ptr] <= i_wr_data;
      // N is a power of two, so the pointer wraps N-1 -> 0 on its own.
      r_wr_ptr        <= r_wr_ptr + LOG2_N'(1);
    end
  end

endmodule

// File: rtl/moving_average_filter.sv
// Boxcar mean of the last 2^LOG2_N accepted samples using a running sum;
// one cycle of latency, one sample per clock.
module moving_average_filter
  import moving_average_filter_pkg::*;
#(
  parameter int unsigned LOG2_N = 3,
  parameter int unsigned ROUND  = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       valid_in,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       valid_out,
  output logic                       primed
);

  localparam int unsigned N      = 1 << LOG2_N;
  localparam int unsigned SUM_W  = sum_width(LOG2_N);
  localparam int unsigned RND_I  = (ROUND != 0) ? (1 << (LOG2_N - 1)) : 0;

  logic signed [SUM_W-1:0] r_sum;
  logic        [LOG2_N:0]  r_fill;
  sample_t                 r_sample_out;
  logic                    r_valid_out;

  sample_t                 w_evict;
  logic                    w_accept;
  logic signed [SUM_W-1:0] w_sum_next;
  logic signed [SUM_W:0]   w_rounded;
  logic signed [SUM_W:0]   w_shifted;
  logic                    w_ovf;
  sample_t                 w_mean;

  assign w_accept = valid_in && !clear;

  moving_average_filter_sample_ring #(
    .LOG2_N(LOG2_N)
  ) u_ring (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_clear   (clear),
    .i_wr_en   (w_accept),
    .i_wr_data (sample_in),
    .o_evict   (w_evict)
  );

  assign w_sum_next = r_sum + SUM_W'(sample_in) - SUM_W'(w_evict);

  // One guard bit keeps the rounding add from ever wrapping the sign.
  assign w_rounded = {w_sum_next[SUM_W-1], w_sum_next} + (SUM_W+1)'(RND_I);
  assign w_shifted = w_rounded >>> LOG2_N;
  assign w_ovf     = (ROUND != 0) && !w_shifted[SUM_W] &&
                     (|w_shifted[SUM_W-1:SAMPLE_W-1]);
  assign w_mean    = w_ovf ? sample_t'(16'sh7FFF) : w_shifted[SAMPLE_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sum        <= '0;
      r_fill       <= '0;
      r_sample_out <= '0;
      r_valid_out  <= 1'b0;
    end else if (clear) begin
      r_sum       <= '0;
      r_fill      <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= valid_in;
      if (valid_in) begin
        r_sum        <= w_sum_next;
        r_sample_out <= w_mean;
        if (r_fill != (LOG2_N+1)'(N)) begin
          r_fill <= r_fill + (LOG2_N+1)'(1);
        end
      end
    end
  end

  assign sample_out = r_sample_out;
  assign valid_out  = r_valid_out;
  assign primed     = (r_fill == (LOG2_N+1)'(N));

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed and random checks of moving_average_filter across window sizes
// and rounding modes; all six instances share one input stream.
module tb_moving_average_filter;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;
  logic valid_in;
  logic signed [15:0] sample_in;

  logic signed [15:0] so [6];
  logic               vo [6];
  logic               pr [6];

  int n_tests = 0;
  int n_fail  = 0;

  // Soak reference model: flat history of the last 64 accepted samples.
  int hist [64];
  int hp;
  int fillc;
  int exp_so [6];
  logic exp_vo;
  int cfg_l [6] = '{3, 3, 1, 1, 6, 6};
  int cfg_r [6] = '{0, 1, 0, 1, 0, 1};

  always #5 clk = ~clk;

  moving_average_filter #(.LOG2_N(3), .ROUND(0)) u0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_in(sample_in),
    .valid_in(valid_in), .sample_out(so[0]), .valid_out(vo[0]), .primed(pr[0]));
  moving_average_filter #(.LOG2_N(3), .ROUND(1)) u1 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_in(sample_in),
    .valid_in(valid_in), .sample_out(so[1]), .valid_out(vo[1]), .primed(pr[1]));
  moving_average_filter #(.LOG2_N(1), .ROUND(0)) u2 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_in(sample_in),
    .valid_in(valid_in), .sample_out(so[2]), .valid_out(vo[2]), .primed(pr[2]));
  moving_average_filter #(.LOG2_N(1), .ROUND(1)) u3 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_in(sample_in),
    .valid_in(valid_in), .sample_out(so[3]), .valid_out(vo[3]), .primed(pr[3]));
  moving_average_filter #(.LOG2_N(6), .ROUND(0)) u4 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_in(sample_in),
    .valid_in(valid_in), .sample_out(so[4]), .valid_out(vo[4]), .primed(pr[4]));
  moving_average_filter #(.LOG2_N(6), .ROUND(1)) u5 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .sample_in(sample_in),
    .valid_in(valid_in), .sample_out(so[5]), .valid_out(vo[5]), .primed(pr[5]));

  task automatic step(input logic v, input logic c, input logic signed [15:0] s);
    valid_in  = v;
    clear     = c;
    sample_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 16'sd1000);
      n_tests++;
      if (so[0] !== 16'sd0 || vo[0] !== 1'b0 || pr[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d] out=%0d valid=%b primed=%b expected 0/0/0", k, so[0], vo[0], pr[0]);
      end
    end
    reset_n = 1'b1;
    step(1'b1, 1'b0, 16'sd1000);
    n_tests++;
    if (so[0] !== 16'sd125 || vo[0] !== 1'b1 || pr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first out=%0d valid=%b primed=%b expected 125/1/0", so[0], vo[0], pr[0]);
    end
  endtask

  task automatic test_ramp();
    step(1'b0, 1'b1, 16'sd0);
    n_tests++;
    if (so[0] !== 16'sd125 || vo[0] !== 1'b0 || pr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_clear out=%0d valid=%b primed=%b expected 125/0/0", so[0], vo[0], pr[0]);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 16'sd800);
      n_tests++;
      if (so[0] !== 16'(100 * k) || vo[0] !== 1'b1 || pr[0] !== (k == 8)) begin
        n_fail++;
        $display("FAIL ramp[%0d] out=%0d valid=%b primed=%b expected %0d/1/%0d",
                 k, so[0], vo[0], pr[0], 100 * k, (k == 8));
      end
    end
  endtask

  task automatic test_extremes();
    logic signed [15:0] up [8];
    logic signed [15:0] dn [8];
    up = '{16'sd4095, 16'sd8191, 16'sd12287, 16'sd16383,
           16'sd20479, 16'sd24575, 16'sd28671, 16'sd32767};
    dn = '{16'sd24575, 16'sd16383, 16'sd8191, -16'sd1,
           -16'sd8193, -16'sd16385, -16'sd24577, -16'sd32768};
    step(1'b0, 1'b1, 16'sd0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, 16'sd32767);
      n_tests++;
      if (so[0] !== up[k]) begin
        n_fail++;
        $display("FAIL extreme_up[%0d] out=%0d expected %0d", k, so[0], up[k]);
      end
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, -16'sd32768);
      n_tests++;
      if (so[0] !== dn[k]) begin
        n_fail++;
        $display("FAIL extreme_dn[%0d] out=%0d expected %0d", k, so[0], dn[k]);
      end
    end
  endtask

  task automatic test_rounding();
    step(1'b0, 1'b1, 16'sd0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, (k == 0) ? 16'sd4 : 16'sd0);
      n_tests++;
      if (so[0] !== 16'sd0 || so[1] !== 16'sd1) begin
        n_fail++;
        $display("FAIL round[%0d] floor=%0d round=%0d expected 0/1", k, so[0], so[1]);
      end
    end
    step(1'b1, 1'b0, 16'sd0);
    n_tests++;
    if (so[0] !== 16'sd0 || so[1] !== 16'sd0) begin
      n_fail++;
      $display("FAIL round_evict floor=%0d round=%0d expected 0/0", so[0], so[1]);
    end
  endtask

  task automatic test_gaps_clear();
    step(1'b0, 1'b1, 16'sd0);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 16'sd500);
    n_tests++;
    if (so[0] !== 16'sd500 || pr[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL gap_primed out=%0d primed=%b expected 500/1", so[0], pr[0]);
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 16'sd123);
      n_tests++;
      if (so[0] !== 16'sd500 || vo[0] !== 1'b0 || pr[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL gap_idle[%0d] out=%0d valid=%b primed=%b expected 500/0/1", k, so[0], vo[0], pr[0]);
      end
    end
    step(1'b1, 1'b1, 16'sd900);
    n_tests++;
    if (so[0] !== 16'sd500 || vo[0] !== 1'b0 || pr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_drop out=%0d valid=%b primed=%b expected 500/0/0", so[0], vo[0], pr[0]);
    end
    step(1'b1, 1'b0, 16'sd800);
    n_tests++;
    if (so[0] !== 16'sd100 || vo[0] !== 1'b1 || pr[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_next out=%0d valid=%b primed=%b expected 100/1/0", so[0], vo[0], pr[0]);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b0, 16'sd0);
    n_tests++;
    if (vo[0] !== 1'b0 || so[0] !== 16'sd100) begin
      n_fail++;
      $display("FAIL single_pulse valid=%b out=%0d expected 0/100", vo[0], so[0]);
    end
  endtask

  task automatic test_soak();
    logic v, c;
    logic signed [15:0] s;
    int sv, n;
    longint sum;
    reset_n = 1'b0;
    step(1'b1, 1'b0, 16'sd77);
    step(1'b1, 1'b0, 16'sd77);
    reset_n = 1'b1;
    for (int i = 0; i < 64; i++) hist[i] = 0;
    hp = 0;
    fillc = 0;
    for (int i = 0; i < 6; i++) exp_so[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      v = ($urandom_range(0, 99) < 70);
      c = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 9))
        0:       s = 16'sh7FFF;
        1:       s = 16'sh8000;
        default: s = 16'($urandom);
      endcase
      sv = s;
      if (c) begin
        for (int i = 0; i < 64; i++) hist[i] = 0;
        fillc = 0;
        exp_vo = 1'b0;
      end else if (v) begin
        hist[hp] = sv;
        hp = (hp + 1) % 64;
        if (fillc < 64) fillc++;
        exp_vo = 1'b1;
        for (int ci = 0; ci < 6; ci++) begin
          n = 1 << cfg_l[ci];
          sum = 0;
          for (int j = 0; j < n; j++) sum += hist[(hp - 1 - j) & 63];
          if (cfg_r[ci] != 0) sum += n / 2;
          sum = sum >>> cfg_l[ci];
          if (sum > 32767) sum = 32767;
          exp_so[ci] = int'(sum);
        end
      end else begin
        exp_vo = 1'b0;
      end
      step(v, c, s);
      for (int ci = 0; ci < 6; ci++) begin
        n_tests++;
        if (so[ci] !== 16'(exp_so[ci]) || vo[ci] !== exp_vo ||
            pr[ci] !== (fillc >= (1 << cfg_l[ci]))) begin
          n_fail++;
          $display("FAIL soak cyc=%0d L=%0d R=%0d out=%0d valid=%b primed=%b expected %0d/%b/%0d",
                   cyc, cfg_l[ci], cfg_r[ci], so[ci], vo[ci], pr[ci],
                   exp_so[ci], exp_vo, (fillc >= (1 << cfg_l[ci])));
        end
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    valid_in  = 1'b0;
    sample_in = '0;
    test_reset();
    test_ramp();
    test_extremes();
    test_rounding();
    test_gaps_clear();
    test_back_to_back();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
